board_io_ctrl: RTL



---
 rtl/board_io_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/board_io_ctrl.sv
// Board I/O controller: debounced inputs with sticky edge capture and maskable irq,
// plus shadowed-duty PWM LED outputs, all behind a simple word-addressed register bus.
module board_io_ctrl #(
  parameter int NUM_IN          = 8,
  parameter int NUM_PWM         = 16,
  parameter int PWM_BITS        = 8,
  parameter int PWM_PRESCALE    = 256,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_IN-1:0]   raw_in,
  input  logic                reg_we,
  input  logic                reg_re,
  input  logic [7:0]          reg_addr,
  input  logic [31:0]         reg_wdata,
  output logic [31:0]         reg_rdata,
  output logic                reg_rvalid,
  output logic                irq,
  output logic [NUM_PWM-1:0]  pwm_out
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int PS_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0]     PS_LAST   = PS_W'(PWM_PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] PCNT_LAST = ~PWM_BITS'(1);
  localparam logic [31:0]         CFG_WORD  = {8'h00, 8'(PWM_BITS), 8'(NUM_PWM), 8'(NUM_IN)};

  logic [NUM_IN-1:0]   sync_p0, sync_p1, stable, stable_nxt;
  logic [NUM_IN-1:0]   edge_q, edge_set, edge_clr, irq_en;
  logic [DB_W-1:0]     db_cnt [NUM_IN];
  logic [PWM_BITS-1:0] duty_sh [NUM_PWM];
  logic [PWM_BITS-1:0] duty_sh_nxt [NUM_PWM];
  logic [PWM_BITS-1:0] duty_act [NUM_PWM];
  logic [PS_W-1:0]     psc;
  logic [PWM_BITS-1:0] pcnt;
  logic                tick, pwm_wrap, wr_edge, wr_irq_en;
  logic [31:0]         rd_mux;
  logic                unused_wdata;

  assign unused_wdata = ^reg_wdata;
  assign wr_edge      = reg_we && (reg_addr == 8'h01);
  assign wr_irq_en    = reg_we && (reg_addr == 8'h02);
  assign edge_clr     = wr_edge ? reg_wdata[NUM_IN-1:0] : '0;
  assign edge_set     = stable ^ stable_nxt;
  assign tick         = (psc == PS_LAST);
  assign pwm_wrap     = tick && (pcnt == PCNT_LAST);

  // A channel accepts a new level only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < NUM_IN; i++) begin
      if ((sync_p1[i] != stable[i]) && (db_cnt[i] == DB_LAST)) stable_nxt[i] = sync_p1[i];
    end
  end

  // Write data is folded in here so a wrap in the same cycle picks up the new duty.
  always_comb begin
    for (int i = 0; i < NUM_PWM; i++) begin
      duty_sh_nxt[i] = duty_sh[i];
      if (reg_we && (reg_addr == 8'(16 + i))) duty_sh_nxt[i] = reg_wdata[PWM_BITS-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      8'h00:   rd_mux[NUM_IN-1:0] = stable;
      8'h01:   rd_mux[NUM_IN-1:0] = edge_q;
      8'h02:   rd_mux[NUM_IN-1:0] = irq_en;
      8'h03:   rd_mux = CFG_WORD;
      default: rd_mux = '0;
    endcase
    for (int i = 0; i < NUM_PWM; i++) begin
      if (reg_addr == 8'(16 + i)) rd_mux[PWM_BITS-1:0] = duty_sh[i];
    end
  end

  // Stage p0/p1: synchroniser, then debounce and sticky edge capture (set beats clear).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      stable  <= '0;
      edge_q  <= '0;
      for (int i = 0; i < NUM_IN; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
      stable  <= stable_nxt;
      edge_q  <= (edge_q & ~edge_clr) | edge_set;
      for (int i = 0; i < NUM_IN; i++) begin
        if ((sync_p1[i] == stable[i]) || (db_cnt[i] == DB_LAST)) db_cnt[i] <= '0;
        else db_cnt[i] <= db_cnt[i] + 1'b1;
      end
    end
  end

  // Register bus: reads capture pre-write state, irq follows the registered edge flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_en     <= '0;
      irq        <= 1'b0;
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
    end else begin
      if (wr_irq_en) irq_en <= reg_wdata[NUM_IN-1:0];
      irq        <= |(edge_q & irq_en);
      reg_rvalid <= reg_re;
      reg_rdata  <= reg_re ? rd_mux : '0;
    end
  end

  // PWM: prescaled period counter, duty loaded from shadow only at the period wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      psc     <= '0;
      pcnt    <= '0;
      pwm_out <= '0;
      for (int i = 0; i < NUM_PWM; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      psc <= tick ? '0 : psc + 1'b1;
      if (tick) pcnt <= pwm_wrap ? '0 : pcnt + 1'b1;
      for (int i = 0; i < NUM_PWM; i++) begin
        duty_sh[i] <= duty_sh_nxt[i];
        if (pwm_wrap) duty_act[i] <= duty_sh_nxt[i];
        pwm_out[i] <= (pcnt < duty_act[i]);
      end
    end
  end

endmodule
